// File: rtl/timer_irq_ctrl.sv
// -----------------------------------------------------------------------------
// timer_irq_ctrl
//   Interrupt receiver for timer irq lines. Rising edges on irq_in latch into
//   a pending vector; unmasked pending lines are offered to the consumer one at
//   a time over a req/ack handshake, lowest index first.
//
// Parameters
//   N   number of irq input lines (1..16)
//   IW  width of irq_id, 2**IW >= N
//   CW  width of the lost-event counter (used only with the macro below)
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   irq_in    timer irq lines; only rising edges are events
//   mask      1 = line masked (kept pending, not presented)
//   irq_req   interrupt request to consumer
//   irq_id    index of requested line, valid while irq_req=1
//   irq_ack   consumer acknowledge, sampled only while irq_req=1
//   pending   registered pending vector
//   ovf_cnt   saturating lost-event count (only with TIMER_IRQ_CTRL_OVF_CNT_EN)
//
// Configuration
//   TIMER_IRQ_CTRL_OVF_CNT_EN  defined: ovf_cnt port and counter present.
// -----------------------------------------------------------------------------
module timer_irq_ctrl #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2,
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  irq_in,
   input  logic [N-1:0]  mask,
   output logic          irq_req,
   output logic [IW-1:0] irq_id,
   input  logic          irq_ack,
   output logic [N-1:0]  pending
`ifdef TIMER_IRQ_CTRL_OVF_CNT_EN
   ,
   output logic [CW-1:0] ovf_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      GAP
   } state_t;

   state_t        state;
   logic [N-1:0]  irq_q;
   logic          armed;
   logic [N-1:0]  evt;
   logic [N-1:0]  cand;
   logic [N-1:0]  clr;
   logic [IW-1:0] low_idx;
   logic          found;
   logic          ack_take;

   // armed stays low for the first cycle after reset so a line that is
   // already high at release only loads irq_q and does not count as an edge.
   always_comb begin
      evt      = irq_in & ~irq_q & {N{armed}};
      cand     = pending & ~mask;
      ack_take = (state == REQ) && irq_ack;
      clr      = ack_take ? (N'(1) << irq_id) : '0;
      low_idx  = '0;
      found    = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (cand[i] && !found) begin
            low_idx = IW'(i);
            found   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q   <= '0;
         armed   <= 1'b0;
         pending <= '0;
         irq_req <= 1'b0;
         irq_id  <= '0;
         state   <= IDLE;
      end else begin
         irq_q   <= irq_in;
         armed   <= 1'b1;
         // Set after clear: an edge on the line being acked keeps it pending.
         pending <= (pending & ~clr) | evt;
         case (state)
            IDLE: begin
               if (found) begin
                  irq_id  <= low_idx;
                  irq_req <= 1'b1;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (irq_ack) begin
                  irq_req <= 1'b0;
                  state   <= GAP;
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               irq_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

`ifdef TIMER_IRQ_CTRL_OVF_CNT_EN
   // Uses the pre-clear pending vector, so an edge on the line being acked
   // in the same cycle is counted as lost.
   logic lost;
   assign lost = |(evt & pending);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt <= '0;
      end else if (lost && (ovf_cnt != '1)) begin
         ovf_cnt <= ovf_cnt + CW'(1);
      end
   end
`endif

endmodule
